qam_symbol_packer: RTL
======================

// Module: qam_symbol_packer
// PURPOSE
// - Downstream of the QAM demodulator: takes one 2-bit hard-decision symbol per beat
//   on an Avalon-ST sink and packs SYMS_PER_WORD symbols into one output word.
// - Output is packetised Avalon-ST (sop/eop/empty).
// - Feeds the byte-oriented deframer/FIFO stages.
// PARAMETERS
// - SYM_W          2  bits per input symbol.
// - SYMS_PER_WORD  4  symbols per output word; output width OUT_W = SYM_W*SYMS_PER_WORD (8).
// - MSB_FIRST      1  1: first symbol of a word in bits [OUT_W-1 -: SYM_W]; 0: first symbol in [SYM_W-1:0].
// - EMPTY_W        2  width of empty field, = clog2(SYMS_PER_WORD).
// PORTS
// - clock_clk               in   1        single clock; all logic on the rising edge
// - reset_reset_n           in   1        one clock; reset is asynchronous and active-low
// - asi_in0_data            in   SYM_W    symbol
// - asi_in0_valid           in   1        symbol valid
// - asi_in0_ready           out  1        sink ready
// - asi_in0_startofpacket   in   1        first symbol of packet
// - asi_in0_endofpacket     in   1        last symbol of packet
// - aso_out0_data           out  OUT_W    packed word
// - aso_out0_valid          out  1        word valid
// - aso_out0_ready          in   1        downstream ready
// - aso_out0_startofpacket  out  1        first word of packet
// - aso_out0_endofpacket    out  1        last word of packet
// - aso_out0_empty          out  EMPTY_W  unused symbol slots in the word; nonzero only with eop
// - stat_drop_cnt           out  16       count of symbols discarded; saturates at 16'hFFFF
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - All aso_out0_* = 0.
//   - Accumulator = 0, slot count = 0, stat_drop_cnt = 0, state = IDLE.
// - Handshake:
//   - Sink beat accepted when asi_in0_valid && asi_in0_ready.
//   - asi_in0_ready = !aso_out0_valid || aso_out0_ready (0 during reset).
//   - Source beat completes when aso_out0_valid && aso_out0_ready.
//   - aso_out0_* hold stable while valid && !ready.
// - FSM, state IDLE:
//   - Accepted beat without sop: discarded, stat_drop_cnt += 1.
//   - Beat with sop: loaded into slot 0, move to IN_PKT, first-word flag set.
//   - Beat with sop && eop: emitted directly as a one-symbol word, empty = SYMS_PER_WORD-1; stays in IDLE.
// - FSM, state IN_PKT:
//   - Each accepted beat fills the next slot.
//   - Word is complete on the beat that fills the last slot, or on an eop beat.
//   - On completion, the word loads the output register on the same edge: valid = 1, sop = first-word flag.
//   - On an eop beat: eop = 1, empty = unfilled slot count, state returns to IDLE.
//   - Unfilled slots are zero-padded.
// - Sop while in IN_PKT (missing eop):
//   - Partial accumulator discarded; stat_drop_cnt += filled slots.
//   - The new beat starts a fresh packet in slot 0. No word is emitted for the broken packet.
// - Latency: word appears at the output 1 cycle after the edge that accepted its last symbol.
// - Throughput: 1 symbol/cycle with no bubble while aso_out0_ready = 1.
// - Output register clears valid/sop/eop/empty after a completed source beat with no new word loading.
// - data holds its last value; there is no simultaneous-load conflict because ready gates the sink.
// - stat_drop_cnt saturates rather than wrapping.
// - Reset asserted mid-packet: partial word and pending output word are lost; state returns to IDLE.
// TESTING
// - Sop,s1..s4 = 00,01,11,10 with eop on s4, ready = 1:
//   - One word 8'b00_01_11_10, sop = 1, eop = 1, empty = 0.
//   - Appears 1 cycle after s4.
// - 6-symbol packet (01 x6, eop on 6th):
//   - Word 8'h55 with sop, eop = 0.
//   - Then word 8'b01_01_00_00, eop = 1, empty = 2.
// - Backpressure: hold aso_out0_ready = 0 for 5 cycles with a word pending.
//   - asi_in0_ready = 0 throughout; output word stable.
//   - On release, no symbol is lost or duplicated across a 16-symbol stream.
// - Beats before any sop (3 symbols) -> no output, stat_drop_cnt = 3.
//   - Then a sop at slot 2 of a packet -> stat_drop_cnt = 5 and the new packet is packed from slot 0.
// - MSB_FIRST = 0, symbols 11,00,00,01 with eop -> data = 8'b01_00_00_11.
// - Assert reset_reset_n = 0 after 2 symbols of a packet, then release:
//   - All outputs 0; next sop packet packs correctly from slot 0.

Source files
------------

// File: rtl/qam_symbol_packer.sv
// ============================================================================
// Module      : qam_symbol_packer
// Description : Packs 2-bit hard-decision QAM symbols from an Avalon-ST sink
//               into packetised output words (sop/eop/empty) on an Avalon-ST
//               source, counting symbols that arrive outside a packet.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qam_symbol_packer #(
  parameter int SYM_W         = 2,
  parameter int SYMS_PER_WORD = 4,
  parameter int MSB_FIRST     = 1,
  parameter int EMPTY_W       = 2
) (
  input  logic                           clock_clk,
  input  logic                           reset_reset_n,
  input  logic [SYM_W-1:0]               asi_in0_data,
  input  logic                           asi_in0_valid,
  output logic                           asi_in0_ready,
  input  logic                           asi_in0_startofpacket,
  input  logic                           asi_in0_endofpacket,
  output logic [SYM_W*SYMS_PER_WORD-1:0] aso_out0_data,
  output logic                           aso_out0_valid,
  input  logic                           aso_out0_ready,
  output logic                           aso_out0_startofpacket,
  output logic                           aso_out0_endofpacket,
  output logic [EMPTY_W-1:0]             aso_out0_empty,
  output logic [15:0]                    stat_drop_cnt
);

  localparam int OUT_W = SYM_W * SYMS_PER_WORD;

  localparam logic [0:0]         c_ST_IDLE   = 1'b0;
  localparam logic [0:0]         c_ST_IN_PKT = 1'b1;
  localparam logic [EMPTY_W-1:0] c_LAST_SLOT = EMPTY_W'(SYMS_PER_WORD - 1);
  localparam logic [EMPTY_W-1:0] c_ONE       = EMPTY_W'(1);

  logic [0:0]         state_q, state_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [EMPTY_W-1:0] slot_q, slot_d;
  logic               first_q, first_d;
  logic [OUT_W-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               sop_q, sop_d;
  logic               eop_q, eop_d;
  logic [EMPTY_W-1:0] empty_q, empty_d;
  logic [15:0]        drop_q, drop_d;

  logic               w_accept;
  logic               w_take;
  logic [EMPTY_W-1:0] w_idx;
  logic               w_first;
  logic               w_word_done;
  logic [OUT_W-1:0]   w_word;
  logic [15:0]        w_drop_inc;
  logic [16:0]        w_drop_sum;
  logic [OUT_W-1:0]   w_slot_word [SYMS_PER_WORD];

  // Sink ready is held low while reset is asserted, not just after it.
  assign asi_in0_ready = reset_reset_n & (~valid_q | aso_out0_ready);
  assign w_accept      = asi_in0_valid & asi_in0_ready;

  // A sop beat always lands in slot 0, restarting any partial word.
  assign w_take      = w_accept & ((state_q == c_ST_IN_PKT) | asi_in0_startofpacket);
  assign w_idx       = asi_in0_startofpacket ? '0 : slot_q;
  assign w_first     = asi_in0_startofpacket | first_q;
  assign w_word_done = asi_in0_endofpacket | (w_idx == c_LAST_SLOT);
  assign w_word      = (asi_in0_startofpacket ? '0 : acc_q) | w_slot_word[w_idx];

  for (genvar k = 0; k < SYMS_PER_WORD; k++) begin : g_slot
    if (MSB_FIRST != 0) begin : g_msb
      assign w_slot_word[k] = {{(OUT_W-SYM_W){1'b0}}, asi_in0_data} << (OUT_W - (k + 1) * SYM_W);
    end else begin : g_lsb
      assign w_slot_word[k] = {{(OUT_W-SYM_W){1'b0}}, asi_in0_data} << (k * SYM_W);
    end
  end

  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (w_take) begin
      if (w_word_done && asi_in0_endofpacket) begin
        state_d = c_ST_IDLE;
      end else begin
        state_d = c_ST_IN_PKT;
      end
    end
  end

  always_comb begin
    acc_d      = acc_q;
    slot_d     = slot_q;
    first_d    = first_q;
    data_d     = data_q;
    valid_d    = valid_q;
    sop_d      = sop_q;
    eop_d      = eop_q;
    empty_d    = empty_q;
    w_drop_inc = '0;

    if (valid_q && aso_out0_ready) begin
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      empty_d = '0;
    end

    if (w_accept && !w_take) begin
      w_drop_inc = 16'd1;
    end

    if (w_take) begin
      // A sop arriving mid-packet abandons the symbols already gathered.
      if (asi_in0_startofpacket && (state_q == c_ST_IN_PKT)) begin
        w_drop_inc = {{(16-EMPTY_W){1'b0}}, slot_q};
      end
      if (w_word_done) begin
        data_d  = w_word;
        valid_d = 1'b1;
        sop_d   = w_first;
        eop_d   = asi_in0_endofpacket;
        empty_d = asi_in0_endofpacket ? (c_LAST_SLOT - w_idx) : '0;
        acc_d   = '0;
        slot_d  = '0;
        first_d = 1'b0;
      end else begin
        acc_d   = w_word;
        slot_d  = w_idx + c_ONE;
        first_d = w_first;
      end
    end
  end

  assign w_drop_sum = {1'b0, drop_q} + {1'b0, w_drop_inc};
  assign drop_d     = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      acc_q   <= '0;
      slot_q  <= '0;
      first_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      empty_q <= '0;
      drop_q  <= '0;
    end else begin
      acc_q   <= acc_d;
      slot_q  <= slot_d;
      first_q <= first_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      empty_q <= empty_d;
      drop_q  <= drop_d;
    end
  end

  assign aso_out0_data          = data_q;
  assign aso_out0_valid         = valid_q;
  assign aso_out0_startofpacket = sop_q;
  assign aso_out0_endofpacket   = eop_q;
  assign aso_out0_empty         = empty_q;
  assign stat_drop_cnt          = drop_q;

endmodule

`default_nettype wire
